mips32_if_stage: RTL and testbench

- Instruction-fetch front end for the pipe_MIPS32 core. It sits directly upstream of the ID stage and drives the IR/NPC pair that ID latches.
- Issues word-addressed reads to instruction memory and buffers the returned words in a small prefetch queue, each tagged with its PC.
- Presents queued instructions to ID over a valid/ready handshake.
- Handles taken-branch redirects from EX (flush and refetch) and stops fetching after an HLT opcode (6'h3f).

---
 rtl/mips32_if_stage_if.sv | 29 ++
 rtl/mips32_if_stage.sv | 126 ++++++++++++
 tb/tb_mips32_if_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port, EX redirect input,
// and the IR/NPC valid/ready handoff towards ID.
//   master : the fetch stage (drives imem_req/addr and the IF->ID outputs)
//   slave  : the surroundings (memory, EX, ID)
interface mips32_if_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              if_valid;
    logic [DATA_W-1:0] if_ir;
    logic [ADDR_W-1:0] if_npc;
    logic              id_ready;
    logic              if_halt_seen;

    modport master (
        output imem_req, imem_addr, if_valid, if_ir, if_npc, if_halt_seen,
        input  imem_rdata, br_taken, br_target, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_ir, if_npc, if_halt_seen,
        output imem_rdata, br_taken, br_target, id_ready
    );
endinterface

// File: rtl/mips32_if_stage.sv
// Instruction-fetch front end for pipe_MIPS32.
// Issues word-addressed reads (fixed 1-cycle latency), buffers returned
// words with their PC in a small prefetch queue, and hands IR/NPC to ID
// over valid/ready. A taken branch from EX flushes and refetches; an HLT
// opcode stops fetching once the HLT word itself has been captured.
// Ports:
//   clk1  : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : master side of mips32_if_stage_if (imem, redirect, IF->ID)
module mips32_if_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clk1,
    input  logic             rst_n,
    mips32_if_stage_if.master bus
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [5:0] OP_HLT = 6'h3f;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic              stop_q, stop_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] last_ir_q, last_ir_d;
    logic [ADDR_W-1:0] last_npc_q, last_npc_d;

    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] ent_ir_q [QDEPTH];
    logic [ADDR_W-1:0] ent_pc_q [QDEPTH];

    logic              valid;
    logic              hlt_arriving;
    logic              will_capture;
    logic              pop;
    logic              issue;
    logic [CNT_W-1:0]  occ_next;
    logic [DATA_W-1:0] head_ir;
    logic [ADDR_W-1:0] head_npc;

    always_comb begin
        valid        = (count_q != '0);
        hlt_arriving = inflight_q && (bus.imem_rdata[DATA_W-1 -: 6] == OP_HLT);
        // A redirect discards the response in flight and blocks the pop.
        will_capture = inflight_q && !bus.br_taken;
        pop          = valid && bus.id_ready && !bus.br_taken;
        // Occupancy after this edge. A new request becomes the single
        // in-flight read, so it is allowed only if a slot remains for it.
        occ_next     = count_q + CNT_W'(will_capture) - CNT_W'(pop);
        issue        = rst_n && !stop_q && !bus.br_taken && !hlt_arriving &&
                       (occ_next < CNT_W'(QDEPTH));
        head_ir      = ent_ir_q[head_q];
        head_npc     = ent_pc_q[head_q] + ADDR_W'(1);
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        stop_d     = stop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        last_ir_d  = valid ? head_ir  : last_ir_q;
        last_npc_d = valid ? head_npc : last_npc_q;
        if (bus.br_taken) begin
            pc_d    = bus.br_target;
            stop_d  = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue)        pc_d   = pc_q + ADDR_W'(1);
            if (hlt_arriving) stop_d = 1'b1;
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(will_capture);
            count_d = occ_next;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            stop_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            last_ir_q  <= '0;
            last_npc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            stop_q     <= stop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            last_ir_q  <= last_ir_d;
            last_npc_q <= last_npc_d;
        end
    end

    // Queue payload and request address carry no reset; they are only
    // observed through the valid/inflight flags, which are reset.
    always_ff @(posedge clk1) begin
        if (issue) req_addr_q <= pc_q;
        if (will_capture) begin
            ent_ir_q[tail_q] <= bus.imem_rdata;
            ent_pc_q[tail_q] <= req_addr_q;
        end
    end

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = pc_q;
    assign bus.if_valid     = valid;
    assign bus.if_ir        = valid ? head_ir  : last_ir_q;
    assign bus.if_npc       = valid ? head_npc : last_npc_q;
    assign bus.if_halt_seen = stop_q;

    a_count_bound: assert property (@(posedge clk1) disable iff (!rst_n)
        count_q <= CNT_W'(QDEPTH));
endmodule

// File: tb/tb_mips32_if_stage.sv
module tb_mips32_if_stage;
    localparam logic [31:0] HLT = 32'hfc00_0000;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } exp_t;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    mips32_if_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips32_if_stage #(
        .ADDR_W(32), .DATA_W(32), .QDEPTH(2), .RESET_PC(32'd0)
    ) dut (
        .clk1 (clk1),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem [256];
    exp_t        exp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          delivered = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Reference: from a start PC, the program-order words up to and
    // including the first HLT are what ID must see, each with NPC=PC+1.
    task automatic push_stream(input logic [31:0] start);
        logic [31:0] p;
        exp_t e;
        p = start;
        exp_q.delete();
        for (int k = 0; k < 200; k++) begin
            e.ir  = mem[p[7:0]];
            e.npc = p + 32'd1;
            exp_q.push_back(e);
            if (e.ir[31:26] == 6'h3f) break;
            p = p + 32'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    task automatic drain(input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    // Memory: responds one cycle after a request, otherwise drives an
    // HLT-looking junk word that must never be captured.
    initial begin
        logic        s_req;
        logic [31:0] s_addr;
        bus.imem_rdata = HLT;
        forever begin
            @(negedge clk1);
            s_req  = bus.imem_req;
            s_addr = bus.imem_addr;
            @(posedge clk1);
            #1;
            bus.imem_rdata = s_req ? mem[s_addr[7:0]] : HLT;
        end
    end

    // Scoreboard monitor: every accepted handoff is compared in order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk1);
            if (rst_n && bus.if_valid && bus.id_ready && !bus.br_taken) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_delivery: got IR=%h NPC=%h, expected none", bus.if_ir, bus.if_npc);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_ir", 64'(bus.if_ir), 64'(e.ir));
                    chk("deliver_npc", 64'(bus.if_npc), 64'(e.npc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic redirect(input logic [31:0] t);
        bus.br_taken  = 1'b1;
        bus.br_target = t;
        push_stream(t);
    endtask

    initial begin
        int reqs;
        logic [31:0] w;
        for (int k = 0; k < 256; k++) begin
            w = $urandom;
            if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
            mem[k] = w;
        end
        mem[0] = 32'h2801_0078;
        mem[1] = 32'h0c63_1800;
        mem[2] = 32'h2022_0000;
        mem[7] = HLT;
        mem[20] = HLT;
        mem[30] = HLT;

        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        bus.id_ready  = 1'b1;

        // Reset values
        #3;
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_valid", 64'(bus.if_valid), 64'd0);
        chk("rst_ir", 64'(bus.if_ir), 64'd0);
        chk("rst_npc", 64'(bus.if_npc), 64'd0);
        chk("rst_halt", 64'(bus.if_halt_seen), 64'd0);

        // Streaming from reset into the HLT at word 7
        push_stream(32'd0);
        @(posedge clk1);
        #3;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c < 3) begin
                chk("stream_req", 64'(bus.imem_req), 64'd1);
                chk("stream_addr", 64'(bus.imem_addr), 64'(c));
            end
            if (c < 10) chk("stream_valid", 64'(bus.if_valid), 64'(c >= 2));
            if (c >= 8) chk("halt_no_req", 64'(bus.imem_req), 64'd0);
            if (c == 9) chk("halt_seen", 64'(bus.if_halt_seen), 64'd1);
            tick();
        end
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: restart at 0 with ID stalled
        bus.id_ready = 1'b0;
        redirect(32'd0);
        #1;
        chk("redir_no_req", 64'(bus.imem_req), 64'd0);
        tick();
        bus.br_taken = 1'b0;
        #1;
        chk("halt_cleared", 64'(bus.if_halt_seen), 64'd0);
        reqs = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.imem_req) reqs++;
            tick();
        end
        chk("bp_reqs", 64'(reqs), 64'd2);
        chk("bp_req_low", 64'(bus.imem_req), 64'd0);
        chk("bp_valid", 64'(bus.if_valid), 64'd1);
        bus.id_ready = 1'b1;
        drain(40, "bp_drain");
        chk("bp_halt", 64'(bus.if_halt_seen), 64'd1);

        // Redirect with stale words queued/in flight
        redirect(32'd0);
        tick();
        bus.br_taken = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        bus.id_ready = 1'b0;
        redirect(32'd4);
        tick();
        bus.br_taken = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        chk("flush_valid", 64'(bus.if_valid), 64'd0);
        chk("refetch_req", 64'(bus.imem_req), 64'd1);
        chk("refetch_addr", 64'(bus.imem_addr), 64'd4);
        tick();
        chk("refetch_valid_1", 64'(bus.if_valid), 64'd0);
        tick();
        chk("refetch_valid_2", 64'(bus.if_valid), 64'd1);
        chk("refetch_ir", 64'(bus.if_ir), 64'(mem[4]));
        chk("refetch_npc", 64'(bus.if_npc), 64'd5);
        drain(40, "refetch_drain");

        // Redirect coinciding with HLT arrival
        redirect(32'd5);
        tick();
        bus.br_taken = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("hltbr_rdata", 64'(bus.imem_rdata), 64'(HLT));
        chk("hltbr_no_req", 64'(bus.imem_req), 64'd0);
        redirect(32'd10);
        tick();
        bus.br_taken = 1'b0;
        #1;
        chk("hltbr_halt", 64'(bus.if_halt_seen), 64'd0);
        chk("hltbr_req", 64'(bus.imem_req), 64'd1);
        chk("hltbr_addr", 64'(bus.imem_addr), 64'd10);
        drain(60, "hltbr_drain");
        chk("hltbr_halt_end", 64'(bus.if_halt_seen), 64'd1);

        // Randomized ready and redirects
        for (int c = 0; c < 400; c++) begin
            bus.id_ready = ($urandom % 4) != 0;
            if (($urandom % 12) == 0) redirect(32'($urandom_range(0, 29)));
            else bus.br_taken = 1'b0;
            tick();
        end
        bus.br_taken = 1'b0;
        bus.id_ready = 1'b1;
        drain(80, "rand_drain");

        // Asynchronous reset mid-stream
        redirect(32'd0);
        tick();
        bus.br_taken = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        #4;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 64'(bus.imem_req), 64'd0);
        chk("arst_addr", 64'(bus.imem_addr), 64'd0);
        chk("arst_valid", 64'(bus.if_valid), 64'd0);
        chk("arst_ir", 64'(bus.if_ir), 64'd0);
        chk("arst_npc", 64'(bus.if_npc), 64'd0);
        chk("arst_halt", 64'(bus.if_halt_seen), 64'd0);
        push_stream(32'd0);
        @(posedge clk1);
        #3;
        rst_n = 1'b1;
        #1;
        chk("arst_restart_req", 64'(bus.imem_req), 64'd1);
        chk("arst_restart_addr", 64'(bus.imem_addr), 64'd0);
        drain(40, "arst_drain");
        chk("arst_halt_end", 64'(bus.if_halt_seen), 64'd1);
        chk("delivered_any", 64'(delivered > 30), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
